// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mdu_operand_prep.sv
// Sign-flag and magnitude extraction for incoming operands, plus the
// conditional negate used when the unsigned core result is sign-corrected.
module mdu_operand_prep
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic              a_sign,
  output logic              b_sign,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  input  logic [2*XLEN-1:0] fix_val,
  input  logic              fix_neg,
  output logic [2*XLEN-1:0] fix_out
);

  logic a_signed;
  logic b_signed;

  // MUL is treated as signed x signed; its low word is identical either way.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_sign  = a_signed & rs1[XLEN-1];
  assign b_sign  = b_signed & rs2[XLEN-1];
  assign a_mag   = a_sign ? -rs1 : rs1;
  assign b_mag   = b_sign ? -rs2 : rs2;
  assign fix_out = fix_neg ? -fix_val : fix_val;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divider; otherwise divide ops return 0 in one edge.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2:0]          f3_reg, f3_next;
  logic                a_sign_reg, a_sign_next;
  logic                b_sign_reg, b_sign_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;
  logic [2*XLEN-1:0]   mcand_reg, mcand_next;
  logic [XLEN-1:0]     opb_reg, opb_next;
  logic [XLEN-1:0]     result_reg, result_next;

  logic                in_a_sign, in_b_sign;
  logic [XLEN-1:0]     in_a_mag, in_b_mag;
  logic [2*XLEN-1:0]   fix_val, fix_out;
  logic                fix_neg;
  logic [XLEN-1:0]     fix_result;
  logic                div_op;
  logic [2*XLEN-1:0]   div_acc_next;

  mdu_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3  (funct3_i),
    .rs1     (rs1_data_i),
    .rs2     (rs2_data_i),
    .a_sign  (in_a_sign),
    .b_sign  (in_b_sign),
    .a_mag   (in_a_mag),
    .b_mag   (in_b_mag),
    .fix_val (fix_val),
    .fix_neg (fix_neg),
    .fix_out (fix_out)
  );

`ifdef MDU_DIV_EN
  // acc holds {remainder, dividend/quotient}; opb holds the divisor magnitude.
  logic [XLEN:0] div_diff;
  assign div_diff     = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opb_reg};
  assign div_op       = f3_reg[2];
  assign div_acc_next = div_diff[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
`else
  assign div_op       = 1'b0;
  assign div_acc_next = '0;
`endif

  always_comb begin
    fix_val = acc_reg;
    fix_neg = a_sign_reg ^ b_sign_reg;
    if (div_op) begin
      fix_val = f3_reg[1] ? {{XLEN{1'b0}}, acc_reg[2*XLEN-1:XLEN]}
                          : {{XLEN{1'b0}}, acc_reg[XLEN-1:0]};
      fix_neg = f3_reg[1] ? a_sign_reg : (a_sign_reg ^ b_sign_reg);
    end
  end

  assign fix_result = (f3_reg == F3_MUL || div_op) ? fix_out[XLEN-1:0]
                                                   : fix_out[2*XLEN-1:XLEN];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    f3_next     = f3_reg;
    a_sign_next = a_sign_reg;
    b_sign_next = b_sign_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    opb_next    = opb_reg;
    result_next = result_reg;
    stall_o     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        stall_o = start_i;
        if (start_i) begin
          f3_next     = funct3_i;
          a_sign_next = in_a_sign;
          b_sign_next = in_b_sign;
          cnt_next    = '0;
          opb_next    = in_b_mag;
          state_next  = S_BUSY;
          if (funct3_i[2]) begin
`ifdef MDU_DIV_EN
            acc_next = {{XLEN{1'b0}}, in_a_mag};
            if (rs2_data_i == '0) begin
              result_next = funct3_i[1] ? rs1_data_i : DIV0_Q;
              state_next  = S_DONE;
            end else if (!funct3_i[0] && rs1_data_i == INT_MIN && rs2_data_i == DIV0_Q) begin
              result_next = funct3_i[1] ? '0 : INT_MIN;
              state_next  = S_DONE;
            end
`else
            result_next = '0;
            state_next  = S_DONE;
`endif
          end else begin
            acc_next   = '0;
            mcand_next = {{XLEN{1'b0}}, in_a_mag};
          end
        end
      end
      S_BUSY: begin
        stall_o  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(XLEN - 1)) state_next = S_FIX;
        if (div_op) begin
          acc_next = div_acc_next;
        end else begin
          if (opb_reg[0]) acc_next = acc_reg + mcand_reg;
          mcand_next = mcand_reg << 1;
          opb_next   = opb_reg >> 1;
        end
      end
      S_FIX: begin
        stall_o     = 1'b1;
        result_next = fix_result;
        state_next  = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      f3_reg     <= '0;
      a_sign_reg <= 1'b0;
      b_sign_reg <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      f3_reg     <= f3_next;
      a_sign_reg <= a_sign_next;
      b_sign_reg <= b_sign_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      opb_reg    <= opb_next;
      result_reg <= result_next;
    end
  end

  assign busy_o   = (state_reg == S_BUSY) || (state_reg == S_FIX);
  assign done_o   = (state_reg == S_DONE);
  assign result_o = result_reg;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative; divider vectors run when
// MDU_DIV_EN is defined, the compiled-out divide behaviour otherwise.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iterative dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op, counts accepting+following edges until done_o, and
  // counts cycles with stall_o high before the done cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [31:0] res, output int edges,
                        output int stalls, output bit got);
    @(negedge clk);
    funct3_i = f3; rs1_data_i = a; rs2_data_i = b; start_i = 1'b1;
    edges = 0; stalls = 0; got = 1'b0;
    while (!got && edges < 100) begin
      #1;
      if (stall_o) stalls++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      if (done_o) got = 1'b1;
    end
    res = result_o;
    $display("op f3=%0d a=%h b=%h result=%h edges=%0d stalls=%0d", f3, a, b, res, edges, stalls);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
    logic [31:0] res;
    int edges, stalls;
    bit got;
    run_op(f3, a, b, 1'b0, res, edges, stalls, got);
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_res"}, res, exp);
    check({tag, "_lat"}, 32'(edges), 32'(exp_edges));
  endtask

  initial begin
    logic [31:0] res;
    int edges, stalls, pulses;
    bit got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);

    // MUL 7 * -3 with full timing checks
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, res, edges, stalls, got);
    check("mul_done", 32'(got), 32'd1);
    check("mul_res", res, 32'hFFFF_FFEB);
    check("mul_lat", 32'(edges), 32'd34);
    check("mul_stalls", 32'(stalls), 32'd34);
    check("mul_stall_in_done", 32'(stall_o), 32'd0);
    @(negedge clk);
    check("mul_done_pulse", 32'(done_o), 32'd0);
    check("mul_result_held", result_o, 32'hFFFF_FFEB);

    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    do_op("mul67", 3'b000, 32'd6, 32'd7, 32'd42, 34);

`ifdef MDU_DIV_EN
    do_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    do_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`else
    do_op("div_off", 3'b100, 32'd10, 32'd2, 32'd0, 1);
    do_op("mul_after_div_off", 3'b000, 32'd6, 32'd7, 32'd42, 34);
`endif

    // Reset part-way through a multiply aborts without a done pulse
    @(negedge clk);
    funct3_i = 3'b000; rs1_data_i = 32'd9; rs2_data_i = 32'd9; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_result", result_o, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    $display("op abort after 10 iterations done_pulses=%0d", pulses);

    // start_i held through DONE: one pulse, then a fresh op from IDLE
    run_op(3'b000, 32'd3, 32'd5, 1'b1, res, edges, stalls, got);
    check("hold_res", res, 32'd15);
    check("hold_lat", 32'(edges), 32'd34);
    funct3_i = 3'b011; rs1_data_i = 32'h0001_0000; rs2_data_i = 32'h0001_0000;
    @(posedge clk);
    @(negedge clk);
    check("hold_single_pulse", 32'(done_o), 32'd0);
    check("hold_idle", 32'(busy_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    check("hold_restart", 32'(busy_o), 32'd1);
    got = 1'b0;
    edges = 1;
    while (!got && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done_o) got = 1'b1;
    end
    check("restart_done", 32'(got), 32'd1);
    check("restart_res", result_o, 32'd1);
    check("restart_lat", 32'(edges), 32'd34);
    $display("op restart f3=3 result=%h edges=%0d", result_o, edges);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
